taxi_debounce_event: RTL and testbench

Multi-channel GPIO input conditioner for board buttons and switches, placed between the raw pads and the design core. It synchronises and debounces each channel, with a per-channel polarity mask. It produces per-channel rise, fall and long-press pulses. A valid/ready event stream reports (channel, type) records with sticky overflow flags, so a soft CPU or UART console can consume button activity without polling.

---
 rtl/taxi_debounce_event.sv | 177 +++++++++++++++++
 tb/tb_taxi_debounce_event.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/taxi_debounce_event.sv
// Multi-channel button/switch conditioner: two-flop sync, N-sample debounce,
// rise/fall/long-press pulses and a valid/ready event stream with sticky overflow.
module taxi_debounce_event #(
    parameter int WIDTH      = 8,
    parameter int N          = 4,
    parameter int RATE       = 125000,
    parameter int LONG_TICKS = 500,
    parameter logic [WIDTH-1:0] INVERT = '0
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [WIDTH-1:0]                         in,
    output logic [WIDTH-1:0]                         out,
    output logic [WIDTH-1:0]                         rise,
    output logic [WIDTH-1:0]                         fall,
    output logic [WIDTH-1:0]                         long,
    output logic                                     evt_valid,
    input  logic                                     evt_ready,
    output logic [((WIDTH > 1) ? $clog2(WIDTH) : 1)-1:0] evt_chan,
    output logic [1:0]                               evt_type,
    output logic [WIDTH-1:0]                         evt_overflow,
    input  logic                                     ovf_clr
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int PW = (RATE > 1) ? $clog2(RATE) : 1;
    localparam int HW = (LONG_TICKS > 0) ? $clog2(LONG_TICKS + 1) : 1;
    localparam int NF = 3 * WIDTH;
    localparam logic [NF-1:0] RISE_MASK = {WIDTH{3'b010}};
    localparam logic [NF-1:0] LONG_MASK = {WIDTH{3'b100}};

    logic [PW-1:0]    presc_reg;
    logic             tick;
    logic [WIDTH-1:0] sync1_reg;
    logic [WIDTH-1:0] sync2_reg;

    assign tick = (presc_reg == PW'(RATE - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_reg <= '0;
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            presc_reg <= tick ? '0 : presc_reg + 1'b1;
            sync1_reg <= in ^ INVERT;
            sync2_reg <= sync1_reg;
        end
    end

    // Flag layout: three bits per channel {long, rise, fall}, so the lowest set
    // bit of the flat vector is exactly the fixed selection priority.
    logic [NF-1:0]    pend_reg;
    logic [NF-1:0]    set_vec;
    logic [NF-1:0]    sel_oh;
    logic [NF-1:0]    clr_vec;
    logic [WIDTH-1:0] chan_hit;
    logic [WIDTH-1:0] ovf_hit;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
        logic [N-1:0] shift_reg;
        logic [N-1:0] shift_next;
        logic         out_reg;
        logic         out_new;
        logic         rise_reg;
        logic         fall_reg;
        logic         long_ch;

        assign shift_next = {shift_reg[N-2:0], sync2_reg[gi]};

        always_comb begin
            out_new = out_reg;
            if (tick) begin
                if (&shift_next) begin
                    out_new = 1'b1;
                end else if (~|shift_next) begin
                    out_new = 1'b0;
                end
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                shift_reg <= '0;
                out_reg   <= 1'b0;
                rise_reg  <= 1'b0;
                fall_reg  <= 1'b0;
            end else begin
                if (tick) begin
                    shift_reg <= shift_next;
                end
                out_reg  <= out_new;
                rise_reg <= out_new & ~out_reg;
                fall_reg <= ~out_new & out_reg;
            end
        end

        if (LONG_TICKS > 0) begin : g_long
            logic [HW-1:0] hold_reg;
            logic          long_reg;

            // Only ticks where the level stays high count, so a release on the
            // threshold tick never produces a long pulse.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    hold_reg <= '0;
                    long_reg <= 1'b0;
                end else begin
                    if (!out_reg) begin
                        hold_reg <= '0;
                    end else if (tick && out_new && hold_reg != HW'(LONG_TICKS)) begin
                        hold_reg <= hold_reg + 1'b1;
                    end
                    long_reg <= tick && out_reg && out_new && (hold_reg == HW'(LONG_TICKS - 1));
                end
            end
            assign long_ch = long_reg;
        end else begin : g_nolong
            assign long_ch = 1'b0;
        end

        assign out[gi]           = out_reg;
        assign rise[gi]          = rise_reg;
        assign fall[gi]          = fall_reg;
        assign long[gi]          = long_ch;
        assign set_vec[3*gi +: 3] = {long_ch, rise_reg, fall_reg};
        assign chan_hit[gi]      = |sel_oh[3*gi +: 3];
        assign ovf_hit[gi]       = |(set_vec[3*gi +: 3] & pend_reg[3*gi +: 3] & ~clr_vec[3*gi +: 3]);
    end

    logic [CW-1:0]    sel_chan;
    logic [1:0]       sel_type;
    logic             load;
    logic             valid_reg;
    logic [CW-1:0]    chan_reg;
    logic [1:0]       type_reg;
    logic [WIDTH-1:0] ovf_reg;

    assign sel_oh   = pend_reg & (~pend_reg + 1'b1);
    assign sel_type = {|(sel_oh & LONG_MASK), |(sel_oh & RISE_MASK)};
    assign load     = (!valid_reg || evt_ready) && (|pend_reg);
    assign clr_vec  = load ? sel_oh : '0;

    always_comb begin
        sel_chan = '0;
        for (int c = 0; c < WIDTH; c++) begin
            if (chan_hit[c]) begin
                sel_chan = CW'(c);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_reg  <= '0;
            ovf_reg   <= '0;
            valid_reg <= 1'b0;
            chan_reg  <= '0;
            type_reg  <= '0;
        end else begin
            pend_reg <= (pend_reg & ~clr_vec) | set_vec;
            ovf_reg  <= (ovf_clr ? '0 : ovf_reg) | ovf_hit;
            if (load) begin
                valid_reg <= 1'b1;
                chan_reg  <= sel_chan;
                type_reg  <= sel_type;
            end else if (evt_ready) begin
                valid_reg <= 1'b0;
            end
        end
    end

    assign evt_valid    = valid_reg;
    assign evt_chan     = chan_reg;
    assign evt_type     = type_reg;
    assign evt_overflow = ovf_reg;

endmodule

// File: tb/tb_taxi_debounce_event.sv
// Bench for taxi_debounce_event: directed steps plus random traffic, checked
// cycle by cycle against a run-length/priority-table reference model.
module tb_taxi_debounce_event;
    localparam int W  = 4;
    localparam int NN = 4;
    localparam int RT = 4;
    localparam int LT = 8;

    logic       clk;
    logic       rst;
    logic [3:0] din;
    logic [3:0] dout, rise, fall, lng, ovf;
    logic       evt_valid, evt_ready, ovf_clr;
    logic [1:0] evt_chan, evt_type;

    logic [3:0] din_inv, dout_inv, rise_inv, fall_inv, lng_inv, ovf_inv;
    logic       valid_inv, ready_inv, clr_inv;
    logic [1:0] chan_inv, type_inv;

    taxi_debounce_event #(.WIDTH(W), .N(NN), .RATE(RT), .LONG_TICKS(LT), .INVERT(4'b0000)) dut (
        .clk(clk), .rst(rst), .in(din), .out(dout), .rise(rise), .fall(fall), .long(lng),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_chan(evt_chan), .evt_type(evt_type),
        .evt_overflow(ovf), .ovf_clr(ovf_clr)
    );

    taxi_debounce_event #(.WIDTH(W), .N(NN), .RATE(RT), .LONG_TICKS(LT), .INVERT(4'b0001)) dut_inv (
        .clk(clk), .rst(rst), .in(din_inv), .out(dout_inv), .rise(rise_inv), .fall(fall_inv),
        .long(lng_inv), .evt_valid(valid_inv), .evt_ready(ready_inv), .evt_chan(chan_inv),
        .evt_type(type_inv), .evt_overflow(ovf_inv), .ovf_clr(clr_inv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc_n = 0;

    // Reference model state
    int         edge_idx;
    logic [3:0] p1, p2;
    logic       run_val [4];
    int         run_len [4];
    int         press   [4];
    logic [3:0] m_out, m_rise, m_fall, m_long, m_ovf;
    logic       pend_m  [4][3];
    logic       m_v;
    int         m_chan, m_type;

    // Observation bookkeeping
    int rise_cnt [4], fall_cnt [4], long_cnt [4];
    int rise_at  [4], long_at  [4];
    int acc_chan [$];
    int acc_type [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        edge_idx = 0;
        p1 = '0; p2 = '0;
        m_out = '0; m_rise = '0; m_fall = '0; m_long = '0; m_ovf = '0;
        m_v = 1'b0; m_chan = 0; m_type = 0;
        for (int c = 0; c < 4; c++) begin
            run_val[c] = 1'b0;
            run_len[c] = NN;
            press[c]   = 0;
            for (int t = 0; t < 3; t++) pend_m[c][t] = 1'b0;
        end
    endtask

    task automatic model_edge();
        logic [3:0] pr, pf, pl, hit, samp;
        logic       found, load, tick, s, cl, old_o, new_o;
        int         sc, st;
        pr = m_rise; pf = m_fall; pl = m_long;
        found = 1'b0; sc = 0; st = 0; hit = '0;
        for (int c = 0; c < 4; c++)
            for (int t = 0; t < 3; t++)
                if (!found && pend_m[c][t]) begin
                    found = 1'b1; sc = c; st = t;
                end
        load = found && (!m_v || evt_ready);
        for (int c = 0; c < 4; c++)
            for (int t = 0; t < 3; t++) begin
                s  = (t == 0) ? pf[c] : ((t == 1) ? pr[c] : pl[c]);
                cl = load && (sc == c) && (st == t);
                if (s && pend_m[c][t] && !cl) hit[c] = 1'b1;
                pend_m[c][t] = (pend_m[c][t] && !cl) || s;
            end
        m_ovf = (ovf_clr ? 4'b0000 : m_ovf) | hit;
        if (load) begin
            m_v = 1'b1; m_chan = sc; m_type = st;
        end else if (evt_ready) begin
            m_v = 1'b0;
        end
        // Debounce: a level is accepted once the last N tick samples agree.
        tick = ((edge_idx % RT) == RT - 1);
        samp = p2; p2 = p1; p1 = din;
        m_rise = '0; m_fall = '0; m_long = '0;
        if (tick) begin
            for (int c = 0; c < 4; c++) begin
                if (samp[c] == run_val[c]) run_len[c]++;
                else begin
                    run_val[c] = samp[c];
                    run_len[c] = 1;
                end
                old_o = m_out[c];
                new_o = (run_len[c] >= NN) ? run_val[c] : old_o;
                if (old_o && new_o) begin
                    press[c]++;
                    if (LT > 0 && press[c] == LT) m_long[c] = 1'b1;
                end else begin
                    press[c] = 0;
                end
                m_out[c]  = new_o;
                m_rise[c] = !old_o && new_o;
                m_fall[c] = old_o && !new_o;
            end
        end
        edge_idx++;
    endtask

    task automatic check_all();
        chk("out", 32'(dout), 32'(m_out));
        chk("rise", 32'(rise), 32'(m_rise));
        chk("fall", 32'(fall), 32'(m_fall));
        chk("long", 32'(lng), 32'(m_long));
        chk("evt_valid", 32'(evt_valid), 32'(m_v));
        chk("evt_overflow", 32'(ovf), 32'(m_ovf));
        if (m_v) begin
            chk("evt_chan", 32'(evt_chan), 32'(m_chan));
            chk("evt_type", 32'(evt_type), 32'(m_type));
        end
    endtask

    task automatic clr_obs();
        acc_chan.delete();
        acc_type.delete();
        for (int c = 0; c < 4; c++) begin
            rise_cnt[c] = 0; fall_cnt[c] = 0; long_cnt[c] = 0;
            rise_at[c] = -1; long_at[c] = -1;
        end
    endtask

    task automatic cyc(input logic [3:0] d, input logic r, input logic c);
        din = d; evt_ready = r; ovf_clr = c;
        if (evt_valid && r) begin
            $display("accept chan=%0d type=%0d cycle=%0d", evt_chan, evt_type, cyc_n);
            acc_chan.push_back(int'(evt_chan));
            acc_type.push_back(int'(evt_type));
        end
        if (!rst) model_edge();
        @(posedge clk);
        @(negedge clk);
        cyc_n++;
        check_all();
        for (int k = 0; k < 4; k++) begin
            if (rise[k]) begin
                rise_cnt[k]++;
                if (rise_at[k] < 0) rise_at[k] = cyc_n;
            end
            if (lng[k]) begin
                long_cnt[k]++;
                if (long_at[k] < 0) long_at[k] = cyc_n;
            end
            if (fall[k]) fall_cnt[k]++;
        end
    endtask

    task automatic mid_reset();
        rst = 1'b1;
        #1;
        chk("rst_async_out", 32'(dout), 0);
        chk("rst_async_pulses", 32'(rise | fall | lng), 0);
        chk("rst_async_valid", 32'(evt_valid), 0);
        chk("rst_async_ovf", 32'(ovf), 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    int         n, cs;
    logic       seen;
    logic [3:0] d;
    logic       r, cl;

    initial begin
        rst = 1'b1; din = '0; evt_ready = 1'b0; ovf_clr = 1'b0;
        din_inv = '0; ready_inv = 1'b1; clr_inv = 1'b0;
        model_reset();
        clr_obs();
        repeat (3) @(negedge clk);
        chk("reset_out", 32'(dout), 0);
        chk("reset_valid", 32'(evt_valid), 0);
        chk("reset_inv_out", 32'(dout_inv), 0);
        rst = 1'b0;

        // 1: idle after reset
        repeat (100) cyc(4'b0000, 1'b0, 1'b0);
        chk("t1_out", 32'(dout), 0);
        chk("t1_pulses", 32'(rise_cnt[0] + rise_cnt[1] + rise_cnt[2] + rise_cnt[3]), 0);
        chk("t1_valid", 32'(evt_valid), 0);
        chk("t1_ovf", 32'(ovf), 0);
        chk("inv_out", 32'(dout_inv), 32'h1);

        // 2: single press on channel 1
        clr_obs();
        cs = cyc_n;
        repeat (40) cyc(4'b0010, 1'b1, 1'b0);
        chk("t2_out1", 32'(dout[1]), 1);
        chk("t2_rise_once", 32'(rise_cnt[1]), 1);
        chk("t2_latency_ok", 32'((rise_at[1] - cs >= 1) && (rise_at[1] - cs <= 18)), 1);
        n = 0;
        foreach (acc_chan[k]) if (acc_chan[k] == 1 && acc_type[k] == 1) n++;
        chk("t2_rise_event", 32'(n), 1);

        // 3: glitches shorter than N ticks on channel 2
        clr_obs();
        d = 4'b0010;
        for (int k = 0; k < 200; k++) begin
            if (k % 6 == 0) d[2] = ~d[2];
            cyc(d, 1'b1, 1'b0);
        end
        n = 0;
        foreach (acc_chan[k]) if (acc_chan[k] == 2) n++;
        chk("t3_no_rise", 32'(rise_cnt[2]), 0);
        chk("t3_no_events", 32'(n), 0);
        repeat (40) cyc(4'b0000, 1'b1, 1'b0);

        // 4: long press on channel 0
        clr_obs();
        repeat (80) cyc(4'b0001, 1'b1, 1'b0);
        repeat (40) cyc(4'b0000, 1'b1, 1'b0);
        chk("t4_rise", 32'(rise_cnt[0]), 1);
        chk("t4_long", 32'(long_cnt[0]), 1);
        chk("t4_fall", 32'(fall_cnt[0]), 1);
        chk("t4_long_delay", 32'(long_at[0] - rise_at[0]), 32);
        chk("t4_event_count", 32'(acc_chan.size()), 3);
        if (acc_chan.size() == 3) begin
            chk("t4_order0", 32'(acc_type[0]), 1);
            chk("t4_order1", 32'(acc_type[1]), 2);
            chk("t4_order2", 32'(acc_type[2]), 0);
        end

        // 5: overflow on channel 3 while the consumer stalls
        clr_obs();
        repeat (24) cyc(4'b1000, 1'b0, 1'b0);
        repeat (24) cyc(4'b0000, 1'b0, 1'b0);
        repeat (24) cyc(4'b1000, 1'b0, 1'b0);
        repeat (48) cyc(4'b0000, 1'b0, 1'b0);
        chk("t5_ovf_set", 32'(ovf), 32'h8);
        repeat (10) cyc(4'b0000, 1'b1, 1'b0);
        chk("t5_delivered", 32'(acc_chan.size()), 3);
        cyc(4'b0000, 1'b1, 1'b1);
        chk("t5_ovf_clr", 32'(ovf), 0);

        // 6: simultaneous rises, stalled consumer
        clr_obs();
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            cyc(4'b0101, 1'b0, 1'b0);
            if (evt_valid) seen = 1'b1;
        end
        chk("t6_valid_seen", 32'(seen), 1);
        for (int k = 0; k < 3; k++) begin
            cyc(4'b0101, 1'b0, 1'b0);
            chk("t6_stall_valid", 32'(evt_valid), 1);
            chk("t6_stall_chan", 32'(evt_chan), 0);
            chk("t6_stall_type", 32'(evt_type), 1);
        end
        cyc(4'b0101, 1'b1, 1'b0);
        chk("t6_next_valid", 32'(evt_valid), 1);
        chk("t6_next_chan", 32'(evt_chan), 2);
        chk("t6_next_type", 32'(evt_type), 1);
        repeat (60) cyc(4'b0000, 1'b1, 1'b0);

        // Random traffic with stall bursts, overflow clears and mid-run resets
        d = '0;
        for (int k = 0; k < 2400; k++) begin
            for (int c = 0; c < 4; c++)
                if ($urandom_range(0, 11) == 0) d[c] = ~d[c];
            r  = ((k % 200) < 60) ? 1'b0 : ($urandom_range(0, 3) != 0);
            cl = ($urandom_range(0, 39) == 0);
            cyc(d, r, cl);
            if (k == 800 || k == 1700) mid_reset();
        end
        repeat (80) cyc(4'b0000, 1'b1, 1'b0);
        chk("final_drained", 32'(evt_valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
